// File: rtl/nearest_centroid_select.sv
// Nearest-centroid selector: takes K distances per point, emits the argmin label and keeps
// per-cluster membership counts and coordinate sums for the centroid-update stage.
module nearest_centroid_select #(
    parameter int unsigned K       = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned DIST_W  = 32,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned SUM_W   = 26
) (
    input  logic               select_clk,
    input  logic               select_rst,
    input  logic               start,
    input  logic [COORD_W-1:0] point_x,
    input  logic [COORD_W-1:0] point_y,
    input  logic               dist_valid,
    input  logic [DIST_W-1:0]  dist_in,
    output logic               dist_ready,
    output logic [IDX_W-1:0]   label,
    output logic               label_valid,
    output logic               busy,
    input  logic               acc_clear,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [CNT_W-1:0]   rd_count,
    output logic [SUM_W-1:0]   rd_sum_x,
    output logic [SUM_W-1:0]   rd_sum_y,
    output logic               overflow
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StUpdate  = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [DIST_W-1:0]    best_dist_q, best_dist_d;
    logic [IDX_W-1:0]     best_idx_q, best_idx_d;
    logic [IDX_W-1:0]     cnt_k_q, cnt_k_d;
    logic [COORD_W-1:0]   px_q, px_d;
    logic [COORD_W-1:0]   py_q, py_d;
    logic [IDX_W-1:0]     label_q, label_d;
    logic                 label_valid_q, label_valid_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_W-1:0]     count_q [K];
    logic [CNT_W-1:0]     count_d [K];
    logic [SUM_W-1:0]     sum_x_q [K];
    logic [SUM_W-1:0]     sum_x_d [K];
    logic [SUM_W-1:0]     sum_y_q [K];
    logic [SUM_W-1:0]     sum_y_d [K];

    always_comb begin
        state_d       = state_q;
        best_dist_d   = best_dist_q;
        best_idx_d    = best_idx_q;
        cnt_k_d       = cnt_k_q;
        px_d          = px_q;
        py_d          = py_q;
        label_d       = label_q;
        label_valid_d = 1'b0;
        overflow_d    = overflow_q;
        count_d       = count_q;
        sum_x_d       = sum_x_q;
        sum_y_d       = sum_y_q;

        unique case (state_q)
            StIdle: begin
                // Clear wins over start so a same-cycle start cannot see stale sums.
                if (acc_clear) begin
                    for (int i = 0; i < int'(K); i++) begin
                        count_d[i] = '0;
                        sum_x_d[i] = '0;
                        sum_y_d[i] = '0;
                    end
                    overflow_d = 1'b0;
                end else if (start) begin
                    px_d        = point_x;
                    py_d        = point_y;
                    best_dist_d = '1;
                    best_idx_d  = '0;
                    cnt_k_d     = '0;
                    state_d     = StCollect;
                end
            end
            StCollect: begin
                if (dist_valid) begin
                    // Strict compare keeps the lowest index on ties.
                    if (dist_in < best_dist_q) begin
                        best_dist_d = dist_in;
                        best_idx_d  = cnt_k_q;
                    end
                    cnt_k_d = cnt_k_q + 1'b1;
                    if (cnt_k_q == IDX_W'(K - 1)) begin
                        state_d = StUpdate;
                    end
                end
            end
            StUpdate: begin
                if (count_q[best_idx_q] == '1) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d[best_idx_q] = count_q[best_idx_q] + 1'b1;
                    sum_x_d[best_idx_q] = sum_x_q[best_idx_q] + SUM_W'(px_q);
                    sum_y_d[best_idx_q] = sum_y_q[best_idx_q] + SUM_W'(py_q);
                end
                // Label and its valid are registered on entry to DONE so they appear together.
                label_d       = best_idx_q;
                label_valid_d = 1'b1;
                state_d       = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge select_clk or negedge select_rst) begin
        if (!select_rst) begin
            state_q       <= StIdle;
            best_dist_q   <= '0;
            best_idx_q    <= '0;
            cnt_k_q       <= '0;
            px_q          <= '0;
            py_q          <= '0;
            label_q       <= '0;
            label_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            count_q       <= '{default: '0};
            sum_x_q       <= '{default: '0};
            sum_y_q       <= '{default: '0};
        end else begin
            state_q       <= state_d;
            best_dist_q   <= best_dist_d;
            best_idx_q    <= best_idx_d;
            cnt_k_q       <= cnt_k_d;
            px_q          <= px_d;
            py_q          <= py_d;
            label_q       <= label_d;
            label_valid_q <= label_valid_d;
            overflow_q    <= overflow_d;
            count_q       <= count_d;
            sum_x_q       <= sum_x_d;
            sum_y_q       <= sum_y_d;
        end
    end

    assign dist_ready  = (state_q == StCollect);
    assign busy        = (state_q != StIdle);
    assign label       = label_q;
    assign label_valid = label_valid_q;
    assign overflow    = overflow_q;
    assign rd_count    = count_q[rd_idx];
    assign rd_sum_x    = sum_x_q[rd_idx];
    assign rd_sum_y    = sum_y_q[rd_idx];

endmodule

// File: tb/tb_nearest_centroid_select.sv
// Randomized self-checking bench for nearest_centroid_select against an argmin/accumulator model.
module tb_nearest_centroid_select;

    localparam int K       = 4;
    localparam int IDX_W   = 2;
    localparam int DIST_W  = 32;
    localparam int COORD_W = 10;
    localparam int CNT_W   = 4;
    localparam int SUM_W   = 14;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [COORD_W-1:0] point_x;
    logic [COORD_W-1:0] point_y;
    logic               dist_valid;
    logic [DIST_W-1:0]  dist_in;
    logic               dist_ready;
    logic [IDX_W-1:0]   label;
    logic               label_valid;
    logic               busy;
    logic               acc_clear;
    logic [IDX_W-1:0]   rd_idx;
    logic [CNT_W-1:0]   rd_count;
    logic [SUM_W-1:0]   rd_sum_x;
    logic [SUM_W-1:0]   rd_sum_y;
    logic               overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int m_cnt [K];
    int m_sx  [K];
    int m_sy  [K];
    bit m_ovf;

    nearest_centroid_select #(
        .K       (K),
        .IDX_W   (IDX_W),
        .DIST_W  (DIST_W),
        .COORD_W (COORD_W),
        .CNT_W   (CNT_W),
        .SUM_W   (SUM_W)
    ) dut (
        .select_clk  (clk),
        .select_rst  (rst_n),
        .start       (start),
        .point_x     (point_x),
        .point_y     (point_y),
        .dist_valid  (dist_valid),
        .dist_in     (dist_in),
        .dist_ready  (dist_ready),
        .label       (label),
        .label_valid (label_valid),
        .busy        (busy),
        .acc_clear   (acc_clear),
        .rd_idx      (rd_idx),
        .rd_count    (rd_count),
        .rd_sum_x    (rd_sum_x),
        .rd_sum_y    (rd_sum_y),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < K; i++) begin
            m_cnt[i] = 0;
            m_sx[i]  = 0;
            m_sy[i]  = 0;
        end
        m_ovf = 1'b0;
    endtask

    // Runs one point from IDLE back to IDLE; caller is 1 time unit after a rising edge.
    task automatic run_point(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y,
                             input logic [DIST_W-1:0] d0, input logic [DIST_W-1:0] d1,
                             input logic [DIST_W-1:0] d2, input logic [DIST_W-1:0] d3,
                             input bit gaps, input string tag);
        logic [DIST_W-1:0] d [K];
        int exp_l;
        int g;
        d = '{d0, d1, d2, d3};
        exp_l = 0;
        for (int i = 1; i < K; i++) if (d[i] < d[exp_l]) exp_l = i;

        start = 1'b1; point_x = x; point_y = y;
        @(posedge clk); #1;
        start = 1'b0;
        point_x = COORD_W'($urandom);
        point_y = COORD_W'($urandom);
        n_tests++;
        if (busy !== 1'b1 || dist_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start_accept: busy=%b dist_ready=%b want 1 1", tag, busy, dist_ready);
        end

        for (int i = 0; i < K; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                repeat (g) begin
                    dist_valid = 1'b0;
                    dist_in    = $urandom;
                    start      = 1'($urandom_range(0, 1));
                    acc_clear  = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                start = 1'b0; acc_clear = 1'b0;
            end
            dist_valid = 1'b1;
            dist_in    = d[i];
            @(posedge clk); #1;
        end
        // dist_valid noise in UPDATE/DONE must be ignored.
        dist_valid = 1'($urandom_range(0, 1));
        dist_in    = '0;
        n_tests++;
        if (label_valid !== 1'b0 || busy !== 1'b1 || dist_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s update_state: label_valid=%b busy=%b dist_ready=%b want 0 1 0",
                     tag, label_valid, busy, dist_ready);
        end

        @(posedge clk); #1;
        if (m_cnt[exp_l] == CNT_MAX) m_ovf = 1'b1;
        else begin
            m_cnt[exp_l]++;
            m_sx[exp_l] += int'(x);
            m_sy[exp_l] += int'(y);
        end
        n_tests++;
        if (label_valid !== 1'b1 || label !== IDX_W'(exp_l)) begin
            n_fail++;
            $display("FAIL %s label: label_valid=%b label=%0d want 1 %0d",
                     tag, label_valid, label, exp_l);
        end

        @(posedge clk); #1;
        dist_valid = 1'b0;
        n_tests++;
        if (label_valid !== 1'b0 || busy !== 1'b0 || label !== IDX_W'(exp_l)) begin
            n_fail++;
            $display("FAIL %s idle_return: label_valid=%b busy=%b label=%0d want 0 0 %0d",
                     tag, label_valid, busy, label, exp_l);
        end

        n_tests++;
        if (overflow !== m_ovf) begin
            n_fail++;
            $display("FAIL %s overflow: got %b want %b", tag, overflow, m_ovf);
        end
        for (int i = 0; i < K; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            n_tests++;
            if (rd_count !== CNT_W'(m_cnt[i]) || rd_sum_x !== SUM_W'(m_sx[i]) ||
                rd_sum_y !== SUM_W'(m_sy[i])) begin
                n_fail++;
                $display("FAIL %s acc[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", tag, i,
                         rd_count, rd_sum_x, rd_sum_y, m_cnt[i], m_sx[i], m_sy[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_tests++;
        if (busy !== 1'b0 || dist_ready !== 1'b0 || label_valid !== 1'b0 || label !== '0 ||
            overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b rdy=%b lv=%b label=%0d ovf=%b want all 0",
                     busy, dist_ready, label_valid, label, overflow);
        end
        for (int i = 0; i < K; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            n_tests++;
            if (rd_count !== '0 || rd_sum_x !== '0 || rd_sum_y !== '0) begin
                n_fail++;
                $display("FAIL reset_acc[%0d]: got %0d/%0d/%0d want 0/0/0",
                         i, rd_count, rd_sum_x, rd_sum_y);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_point(10'd100, 10'd200, 32'd50, 32'd20, 32'd35, 32'd90, 1'b0, "basic");
    endtask

    task automatic test_ties();
        run_point(10'd3, 10'd4, 32'd30, 32'd30, 32'd10, 32'd10, 1'b0, "ties_a");
        run_point(10'd5, 10'd6, 32'd7, 32'd7, 32'd7, 32'd7, 1'b0, "ties_b");
        run_point(10'd7, 10'd8, '1, '1, '1, '1, 1'b0, "all_ones");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            run_point(COORD_W'($urandom), COORD_W'($urandom), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 15), $urandom, 1'b0, "b2b");
        end
    endtask

    task automatic test_backpressure();
        for (int n = 0; n < 8; n++) begin
            run_point(COORD_W'($urandom), COORD_W'($urandom), $urandom, $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom, 1'b1, "bp");
        end
    endtask

    task automatic test_saturation();
        // acc_clear with a same-cycle start: clear happens, start is ignored.
        acc_clear = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        acc_clear = 1'b0; start = 1'b0;
        model_clear();
        n_tests++;
        if (busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_start: busy=%b overflow=%b want 0 0", busy, overflow);
        end
        for (int n = 0; n < CNT_MAX + 1; n++) begin
            run_point(10'd1, 10'd2, 32'd5, 32'd100, 32'd200, 32'd300, 1'b0, "sat");
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_sticky: overflow=%b want 1", overflow);
        end
        acc_clear = 1'b1;
        @(posedge clk); #1;
        acc_clear = 1'b0;
        model_clear();
        rd_idx = '0;
        #1;
        n_tests++;
        if (rd_count !== '0 || rd_sum_x !== '0 || rd_sum_y !== '0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clear: got %0d/%0d/%0d ovf=%b want 0/0/0 0",
                     rd_count, rd_sum_x, rd_sum_y, overflow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_point();
        run_point(10'd9, 10'd11, 32'd4, 32'd3, 32'd2, 32'd1, 1'b0, "pre_rst");
        start = 1'b1; point_x = 10'd50; point_y = 10'd60;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dist_valid = 1'b1;
            dist_in    = 32'(i + 1);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || dist_ready !== 1'b0 || label_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state: busy=%b rdy=%b lv=%b ovf=%b want 0 0 0 0",
                     busy, dist_ready, label_valid, overflow);
        end
        for (int i = 0; i < K; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            n_tests++;
            if (rd_count !== '0 || rd_sum_x !== '0 || rd_sum_y !== '0) begin
                n_fail++;
                $display("FAIL midrst_acc[%0d]: got %0d/%0d/%0d want 0/0/0",
                         i, rd_count, rd_sum_x, rd_sum_y);
            end
        end
        repeat (3) begin
            @(posedge clk); #1;
            n_tests++;
            if (label_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_no_label: label_valid=%b want 0", label_valid);
            end
        end
        dist_valid = 1'b0;
        rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
        run_point(10'd77, 10'd88, 32'd900, 32'd800, 32'd1000, 32'd700, 1'b0, "post_rst");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; point_x = '0; point_y = '0;
        dist_valid = 1'b0; dist_in = '0; acc_clear = 1'b0; rd_idx = '0;
        model_clear();
        test_reset();
        test_basic();
        test_ties();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_reset_mid_point();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
